// File: rtl/toy_pack.sv
`default_nettype none
// ============================================================================
// Module      : toy_pack (package)
// Description : Shared widths and the recovery-walk state encoding for the
//               backup architectural rename table.
//               ARCH_ID_WIDTH    - width of an architectural register index
//               PHY_REG_ID_WIDTH - width of a physical register id
//               rec_state_e      - recovery walk states (IDLE, WALK, DONE)
// Revision    : 1.0 - initial release
// ============================================================================
package toy_pack;

  localparam int ARCH_ID_WIDTH    = 5;
  localparam int PHY_REG_ID_WIDTH = 6;

  typedef enum logic [1:0] {
    REC_IDLE = 2'd0,
    REC_WALK = 2'd1,
    REC_DONE = 2'd2
  } rec_state_e;

endpackage : toy_pack
`default_nettype wire

// File: rtl/toy_backup_release_sel.sv
`default_nettype none
// ============================================================================
// Module      : toy_backup_release_sel
// Description : Per commit port, selects the physical id being displaced by
//               that commit: the value written by the youngest older
//               same-cycle port targeting the same arch reg, otherwise the
//               committed table value. Purely combinational.
// Ports       : commit_en / commit_arch_index / commit_phy_index - commit bus
//               table_phy  - table entry currently indexed by each port
//               sel_en     - port displaces a releasable id
//               sel_phy    - displaced id (0 when sel_en is low)
// Revision    : 1.0 - initial release
// ============================================================================
module toy_backup_release_sel
  import toy_pack::*;
#(
  parameter int COMMIT_WIDTH  = 4,
  parameter int ZERO_HARDWIRE = 1
) (
  input  logic [COMMIT_WIDTH-1:0]                       commit_en,
  input  logic [COMMIT_WIDTH-1:0][ARCH_ID_WIDTH-1:0]    commit_arch_index,
  input  logic [COMMIT_WIDTH-1:0][PHY_REG_ID_WIDTH-1:0] commit_phy_index,
  input  logic [COMMIT_WIDTH-1:0][PHY_REG_ID_WIDTH-1:0] table_phy,
  output logic [COMMIT_WIDTH-1:0]                       sel_en,
  output logic [COMMIT_WIDTH-1:0][PHY_REG_ID_WIDTH-1:0] sel_phy
);

  always_comb begin
    sel_en  = '0;
    sel_phy = '0;
    for (int p = 0; p < COMMIT_WIDTH; p++) begin
      // A hardwired arch 0 never owns a releasable id.
      sel_en[p]  = commit_en[p] &&
                   !((ZERO_HARDWIRE != 0) && (commit_arch_index[p] == '0));
      sel_phy[p] = table_phy[p];
      // Scan older ports in age order so the youngest older match wins.
      for (int q = 0; q < p; q++) begin
        if (commit_en[q] && (commit_arch_index[q] == commit_arch_index[p])) begin
          sel_phy[p] = commit_phy_index[q];
        end
      end
      if (!sel_en[p]) begin
        sel_phy[p] = '0;
      end
    end
  end

endmodule : toy_backup_release_sel
`default_nettype wire

// File: rtl/toy_backup_arch_rename_table.sv
`default_nettype none
// ============================================================================
// Module      : toy_backup_arch_rename_table
// Description : Committed (architectural) rename table. Commits update the
//               arch->phy mapping youngest-wins and emit the displaced phy
//               id one cycle later for the free list. Optionally walks the
//               whole table out in RECOVER_WIDTH-entry chunks on request.
// Config      : TOY_BACKUP_RF_RECOVER_EN - when defined, the recovery walk is
//               built; otherwise recover_req is ignored and every recovery
//               output is tied to 0.
// Ports       : clk, rst (sync, active-high)
//               commit_en, commit_arch_index, commit_phy_index - commit bus
//               release_en, release_phy_index - registered released ids
//               recover_req  - pulse to start a table walk
//               recover_busy, recover_vld, recover_arch_base,
//               recover_phy_index, recover_done - walk outputs
// Revision    : 1.0 - initial release
// ============================================================================
module toy_backup_arch_rename_table
  import toy_pack::*;
#(
  parameter int ARCH_REG_NUM  = 32,
  parameter int COMMIT_WIDTH  = 4,
  parameter int RECOVER_WIDTH = 8,
  parameter int ZERO_HARDWIRE = 1
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [COMMIT_WIDTH-1:0]                        commit_en,
  input  logic [COMMIT_WIDTH-1:0][ARCH_ID_WIDTH-1:0]     commit_arch_index,
  input  logic [COMMIT_WIDTH-1:0][PHY_REG_ID_WIDTH-1:0]  commit_phy_index,
  output logic [COMMIT_WIDTH-1:0]                        release_en,
  output logic [COMMIT_WIDTH-1:0][PHY_REG_ID_WIDTH-1:0]  release_phy_index,
  input  logic                                           recover_req,
  output logic                                           recover_busy,
  output logic                                           recover_vld,
  output logic [ARCH_ID_WIDTH-1:0]                       recover_arch_base,
  output logic [RECOVER_WIDTH-1:0][PHY_REG_ID_WIDTH-1:0] recover_phy_index,
  output logic                                           recover_done
);

  logic [PHY_REG_ID_WIDTH-1:0]                       rename_table [ARCH_REG_NUM];
  logic [COMMIT_WIDTH-1:0][PHY_REG_ID_WIDTH-1:0]     table_rd_phy;
  logic [COMMIT_WIDTH-1:0]                           sel_en;
  logic [COMMIT_WIDTH-1:0][PHY_REG_ID_WIDTH-1:0]     sel_phy;

  always_comb begin
    table_rd_phy = '0;
    for (int p = 0; p < COMMIT_WIDTH; p++) begin
      table_rd_phy[p] = rename_table[commit_arch_index[p]];
    end
  end

  toy_backup_release_sel #(
    .COMMIT_WIDTH  (COMMIT_WIDTH),
    .ZERO_HARDWIRE (ZERO_HARDWIRE)
  ) u_release_sel (
    .commit_en         (commit_en),
    .commit_arch_index (commit_arch_index),
    .commit_phy_index  (commit_phy_index),
    .table_phy         (table_rd_phy),
    .sel_en            (sel_en),
    .sel_phy           (sel_phy)
  );

  // Ports are visited oldest first, so the last nonblocking write to an
  // entry (the youngest port) is the one that lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ARCH_REG_NUM; i++) begin
        rename_table[i] <= PHY_REG_ID_WIDTH'(i);
      end
      release_en        <= '0;
      release_phy_index <= '0;
    end else begin
      for (int p = 0; p < COMMIT_WIDTH; p++) begin
        if (commit_en[p] &&
            !((ZERO_HARDWIRE != 0) && (commit_arch_index[p] == '0))) begin
          rename_table[commit_arch_index[p]] <= commit_phy_index[p];
        end
      end
      release_en        <= sel_en;
      release_phy_index <= sel_phy;
    end
  end

`ifdef TOY_BACKUP_RF_RECOVER_EN
  localparam logic [ARCH_ID_WIDTH-1:0] LAST_BASE = ARCH_ID_WIDTH'(ARCH_REG_NUM - RECOVER_WIDTH);
  localparam logic [ARCH_ID_WIDTH-1:0] BASE_STEP = ARCH_ID_WIDTH'(RECOVER_WIDTH);

  rec_state_e                 rec_state;
  logic [ARCH_ID_WIDTH-1:0]   walk_base;
  logic                       walk_vld;
  logic                       walk_busy;
  logic                       walk_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      rec_state <= REC_IDLE;
      walk_base <= '0;
      walk_vld  <= 1'b0;
      walk_busy <= 1'b0;
      walk_done <= 1'b0;
    end else begin
      case (rec_state)
        REC_IDLE: begin
          walk_done <= 1'b0;
          if (recover_req) begin
            rec_state <= REC_WALK;
            walk_base <= '0;
            walk_vld  <= 1'b1;
            walk_busy <= 1'b1;
          end
        end
        REC_WALK: begin
          // Stop on the final chunk instead of letting the base wrap.
          if (walk_base == LAST_BASE) begin
            rec_state <= REC_DONE;
            walk_base <= '0;
            walk_vld  <= 1'b0;
            walk_done <= 1'b1;
          end else begin
            walk_base <= walk_base + BASE_STEP;
          end
        end
        REC_DONE: begin
          rec_state <= REC_IDLE;
          walk_done <= 1'b0;
          walk_busy <= 1'b0;
        end
        default: begin
          rec_state <= REC_IDLE;
          walk_base <= '0;
          walk_vld  <= 1'b0;
          walk_busy <= 1'b0;
          walk_done <= 1'b0;
        end
      endcase
    end
  end

  // Chunk data is read straight from the table so it shows the contents at
  // the start of the cycle, before that cycle's commits are written.
  always_comb begin
    recover_phy_index = '0;
    for (int k = 0; k < RECOVER_WIDTH; k++) begin
      if (walk_vld) begin
        recover_phy_index[k] = rename_table[walk_base + ARCH_ID_WIDTH'(k)];
      end
    end
  end

  assign recover_busy      = walk_busy;
  assign recover_vld       = walk_vld;
  assign recover_arch_base = walk_base;
  assign recover_done      = walk_done;
`else
  logic unused_recover_req;
  assign unused_recover_req = recover_req;

  assign recover_busy      = 1'b0;
  assign recover_vld       = 1'b0;
  assign recover_arch_base = '0;
  assign recover_phy_index = '0;
  assign recover_done      = 1'b0;
`endif

endmodule : toy_backup_arch_rename_table
`default_nettype wire

// File: tb/tb_toy_backup_arch_rename_table.sv
`default_nettype none
// ============================================================================
// Module      : tb_toy_backup_arch_rename_table
// Description : Self-checking bench for toy_backup_arch_rename_table.
//               Directed vector table, randomized commits against an
//               in-order reference model, and recovery walk sequences when
//               TOY_BACKUP_RF_RECOVER_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_toy_backup_arch_rename_table;

  localparam int NA = 32;
  localparam int CW = 4;
  localparam int RW = 8;
  localparam int AW = 5;
  localparam int PW = 6;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [CW-1:0]          commit_en = '0;
  logic [CW-1:0][AW-1:0]  commit_arch_index = '0;
  logic [CW-1:0][PW-1:0]  commit_phy_index = '0;
  logic [CW-1:0]          release_en;
  logic [CW-1:0][PW-1:0]  release_phy_index;
  logic                   recover_req = 1'b0;
  logic                   recover_busy;
  logic                   recover_vld;
  logic [AW-1:0]          recover_arch_base;
  logic [RW-1:0][PW-1:0]  recover_phy_index;
  logic                   recover_done;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: the committed mapping of every arch register.
  int tbl [NA];

  always #5 clk = ~clk;

  toy_backup_arch_rename_table #(
    .ARCH_REG_NUM  (NA),
    .COMMIT_WIDTH  (CW),
    .RECOVER_WIDTH (RW),
    .ZERO_HARDWIRE (1)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .commit_en         (commit_en),
    .commit_arch_index (commit_arch_index),
    .commit_phy_index  (commit_phy_index),
    .release_en        (release_en),
    .release_phy_index (release_phy_index),
    .recover_req       (recover_req),
    .recover_busy      (recover_busy),
    .recover_vld       (recover_vld),
    .recover_arch_base (recover_arch_base),
    .recover_phy_index (recover_phy_index),
    .recover_done      (recover_done)
  );

  typedef struct {
    logic [CW-1:0]         en;
    logic [CW-1:0][AW-1:0] arch;
    logic [CW-1:0][PW-1:0] phy;
    logic [CW-1:0]         rel_en;
    logic [CW-1:0][PW-1:0] rel_phy;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NA; i++) tbl[i] = i;
  endtask

  // Drives one cycle of commits, advances the model in port (age) order and
  // optionally compares the registered release outputs with the model.
  task automatic tick(input logic [CW-1:0] en, input logic [CW-1:0][AW-1:0] arch,
                      input logic [CW-1:0][PW-1:0] phy, input logic req,
                      input bit check_model);
    logic [CW-1:0]         e_en;
    logic [CW-1:0][PW-1:0] e_phy;
    commit_en         = en;
    commit_arch_index = arch;
    commit_phy_index  = phy;
    recover_req       = req;
    e_en  = '0;
    e_phy = '0;
    for (int p = 0; p < CW; p++) begin
      if (en[p] && arch[p] != 0) begin
        e_en[p]  = 1'b1;
        e_phy[p] = PW'(tbl[arch[p]]);
        tbl[arch[p]] = int'(phy[p]);
      end
    end
    @(posedge clk); #1;
    commit_en   = '0;
    recover_req = 1'b0;
    if (check_model) begin
      chk("release_en", 64'(release_en), 64'(e_en));
      chk("release_phy", 64'(release_phy_index), 64'(e_phy));
    end
  endtask

  task automatic gen(input bit active, output logic [CW-1:0] en,
                     output logic [CW-1:0][AW-1:0] arch, output logic [CW-1:0][PW-1:0] phy);
    en = active ? CW'($urandom) : '0;
    for (int p = 0; p < CW; p++) begin
      // Bias toward a few low registers to create same-cycle collisions.
      arch[p] = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, NA - 1));
      phy[p]  = PW'($urandom);
    end
  endtask

  task automatic rand_tick(input bit active, input logic req);
    logic [CW-1:0]         en;
    logic [CW-1:0][AW-1:0] arch;
    logic [CW-1:0][PW-1:0] phy;
    gen(active, en, arch, phy);
    tick(en, arch, phy, req, 1'b1);
  endtask

`ifdef TOY_BACKUP_RF_RECOVER_EN
  task automatic chk_chunk(input int c);
    logic [RW-1:0][PW-1:0] exp;
    for (int k = 0; k < RW; k++) exp[k] = PW'(tbl[c * RW + k]);
    chk("walk_vld", 64'(recover_vld), 64'(1));
    chk("walk_busy", 64'(recover_busy), 64'(1));
    chk("walk_done_low", 64'(recover_done), 64'(0));
    chk("walk_base", 64'(recover_arch_base), 64'(c * RW));
    chk("walk_chunk", 64'(recover_phy_index), 64'(exp));
  endtask

  // Full walk; stray recover_req pulses mid-walk and in DONE must be ignored.
  task automatic do_walk(input bit active);
    rand_tick(active, 1'b1);
    for (int c = 0; c < NA / RW; c++) begin
      chk_chunk(c);
      rand_tick(active, c == 1);
    end
    chk("done_pulse", 64'(recover_done), 64'(1));
    chk("done_busy", 64'(recover_busy), 64'(1));
    chk("done_vld", 64'(recover_vld), 64'(0));
    rand_tick(active, 1'b1);
    chk("post_done", 64'(recover_done), 64'(0));
    chk("post_busy", 64'(recover_busy), 64'(0));
    chk("post_vld", 64'(recover_vld), 64'(0));
    rand_tick(active, 1'b0);
    chk("idle_vld", 64'(recover_vld), 64'(0));
    chk("idle_busy", 64'(recover_busy), 64'(0));
  endtask
`endif

  initial begin
    // port order in concatenations: {port3, port2, port1, port0}
    vecs[0] = '{4'b0001, {5'd0, 5'd0, 5'd0, 5'd5}, {6'd0, 6'd0, 6'd0, 6'd40},
                4'b0001, {6'd0, 6'd0, 6'd0, 6'd5}};
    vecs[1] = '{4'b1010, {5'd7, 5'd7, 5'd7, 5'd7}, {6'd60, 6'd12, 6'd50, 6'd11},
                4'b1010, {6'd50, 6'd0, 6'd7, 6'd0}};
    vecs[2] = '{4'b0001, {5'd0, 5'd0, 5'd0, 5'd0}, {6'd0, 6'd0, 6'd0, 6'd33},
                4'b0000, {6'd0, 6'd0, 6'd0, 6'd0}};
    vecs[3] = '{4'b0100, {5'd0, 5'd5, 5'd0, 5'd0}, {6'd0, 6'd41, 6'd0, 6'd0},
                4'b0100, {6'd0, 6'd40, 6'd0, 6'd0}};
    vecs[4] = '{4'b0001, {5'd0, 5'd0, 5'd0, 5'd7}, {6'd0, 6'd0, 6'd0, 6'd1},
                4'b0001, {6'd0, 6'd0, 6'd0, 6'd60}};
    vecs[5] = '{4'b1111, {5'd9, 5'd9, 5'd0, 5'd0}, {6'd45, 6'd44, 6'd3, 6'd2},
                4'b1100, {6'd44, 6'd9, 6'd0, 6'd0}};
    vecs[6] = '{4'b0111, {5'd0, 5'd3, 5'd3, 5'd3}, {6'd0, 6'd22, 6'd21, 6'd20},
                4'b0111, {6'd0, 6'd21, 6'd20, 6'd3}};

    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_release_en", 64'(release_en), 64'(0));
    chk("rst_release_phy", 64'(release_phy_index), 64'(0));
    chk("rst_busy", 64'(recover_busy), 64'(0));
    chk("rst_vld", 64'(recover_vld), 64'(0));
    chk("rst_done", 64'(recover_done), 64'(0));
    chk("rst_base", 64'(recover_arch_base), 64'(0));
    chk("rst_chunk", 64'(recover_phy_index), 64'(0));
    rst = 1'b0;

`ifdef TOY_BACKUP_RF_RECOVER_EN
    do_walk(1'b0);
`endif

    for (int v = 0; v < 7; v++) begin
      tick(vecs[v].en, vecs[v].arch, vecs[v].phy, 1'b0, 1'b0);
      chk($sformatf("vec%0d_release_en", v), 64'(release_en), 64'(vecs[v].rel_en));
      chk($sformatf("vec%0d_release_phy", v), 64'(release_phy_index), 64'(vecs[v].rel_phy));
    end

`ifdef TOY_BACKUP_RF_RECOVER_EN
    // Table contents after the vectors, including entry 0 still 0.
    do_walk(1'b0);

    // Reset during the second chunk aborts the walk with no done pulse.
    rand_tick(1'b1, 1'b1);
    chk_chunk(0);
    rand_tick(1'b1, 1'b0);
    chk_chunk(1);
    rst = 1'b1;
    tick('0, '0, '0, 1'b0, 1'b1);
    rst = 1'b0;
    model_reset();
    chk("abort_busy", 64'(recover_busy), 64'(0));
    chk("abort_vld", 64'(recover_vld), 64'(0));
    chk("abort_done", 64'(recover_done), 64'(0));
    for (int i = 0; i < 4; i++) begin
      rand_tick(1'b0, 1'b0);
      chk("abort_no_done", 64'(recover_done), 64'(0));
    end
    do_walk(1'b0);
`else
    tick('0, '0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      chk("off_vld", 64'(recover_vld), 64'(0));
      chk("off_busy", 64'(recover_busy), 64'(0));
      chk("off_done", 64'(recover_done), 64'(0));
      chk("off_chunk", 64'(recover_phy_index | 48'(recover_arch_base)), 64'(0));
      rand_tick(1'b0, 1'b0);
    end
`endif

    for (int it = 0; it < 300; it++) begin
`ifdef TOY_BACKUP_RF_RECOVER_EN
      if (it % 50 == 10) do_walk(1'b1);
`endif
      rand_tick(1'b1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_toy_backup_arch_rename_table
`default_nettype wire
